// File: rtl/sfb_pkg.sv
// Shared types and helpers for the STFT analysis-frame buffer.
package sfb_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_EMIT = 2'd1,
    S_EOS  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Pointer width: one extra bit so a full RAM is distinguishable from empty.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stft_frame_buffer_if.sv
// Sample-in / frame-sample-out handshake bundle for the STFT frame buffer.
interface stft_frame_buffer_if #(
  parameter int DATA_W = 16,
  parameter int IW     = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IW-1:0]     out_idx;
  logic              out_first;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_first, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_first, out_last
  );
endinterface

// File: rtl/sfb_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module sfb_sample_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8192,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/stft_frame_buffer.sv
// Circular-RAM frame buffer: emits overlapping WIN_LEN-sample frames every HOP
// input samples, with zero padding after end of stream and synchronous abort.
module stft_frame_buffer
  import sfb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int WIN_LEN = 4096,
  parameter int HOP     = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  stft_frame_buffer_if.slave  bus,
  output logic [15:0]         frame_cnt,
  output logic                done
);

  localparam int DEPTH = 2 * WIN_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = cnt_w(DEPTH);
  localparam int IW    = AW - 1;

  localparam logic [CW-1:0] WIN_C    = CW'(WIN_LEN);
  localparam logic [CW-1:0] HOP_C    = CW'(HOP);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIN_LEN - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     base_q, base_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              eos_q, eos_d;
  logic              run_q, run_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_pad_q, s1_pad_d;
  logic [IW-1:0]     s1_idx_q, s1_idx_d;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [DATA_W-1:0] fifo_data_d [2];
  logic [IW-1:0]     fifo_idx_q [2];
  logic [IW-1:0]     fifo_idx_d [2];
  logic              fifo_head_q, fifo_head_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic [CW-1:0]     avail, rd_off;
  logic              avail_ok, start_ok, accept, pop, rd_fire, space, tail, head_last;
  logic [2:0]        occ;
  logic [DATA_W-1:0] ram_rdata;

  sfb_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_cnt_q[AW-1:0]),
    .wdata (bus.in_data),
    .re    (rd_fire),
    .raddr (rd_cnt_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.in_ready  = run_q & enable & ~eos_q & (avail < DEPTH_C);
  assign bus.out_valid = (fifo_cnt_q != 2'd0);
  assign bus.out_data  = bus.out_valid ? fifo_data_q[fifo_head_q] : '0;
  assign bus.out_idx   = bus.out_valid ? fifo_idx_q[fifo_head_q] : '0;
  assign bus.out_first = bus.out_valid & (fifo_idx_q[fifo_head_q] == '0);
  assign bus.out_last  = bus.out_valid & head_last;
  assign frame_cnt     = frame_cnt_q;
  assign done          = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    base_d      = base_q;
    rd_cnt_d    = rd_cnt_q;
    eos_d       = eos_q;
    run_d       = 1'b1;
    frame_cnt_d = frame_cnt_q;
    fifo_data_d = fifo_data_q;
    fifo_idx_d  = fifo_idx_q;
    fifo_head_d = fifo_head_q;
    fifo_cnt_d  = fifo_cnt_q;

    // Past end of stream base may overtake wr_cnt; that wraps to > DEPTH.
    avail     = wr_cnt_q - base_q;
    avail_ok  = (avail <= DEPTH_C);
    rd_off    = rd_cnt_q - base_q;
    accept    = bus.in_valid & bus.in_ready;
    pop       = bus.out_valid & bus.out_ready;
    head_last = (fifo_idx_q[fifo_head_q] == LAST_IDX);
    start_ok  = ((state_q == S_WAIT) && (avail >= WIN_C) && avail_ok) ||
                ((state_q == S_EOS) && (avail != '0) && avail_ok);

    // Two skid slots cover the read in flight, so out_ready can stall without loss.
    occ     = {1'b0, fifo_cnt_q} + {2'b00, s1_valid_q} - {2'b00, pop};
    space   = (occ < 3'd2);
    rd_fire = enable && ((state_q == S_EMIT) || start_ok) && (rd_off < WIN_C) && space;

    s1_valid_d = rd_fire;
    s1_idx_d   = rd_off[IW-1:0];
    s1_pad_d   = eos_q && (rd_off >= avail);
    if (rd_fire) rd_cnt_d = rd_cnt_q + CW'(1);

    if (accept) begin
      wr_cnt_d = wr_cnt_q + CW'(1);
      if (bus.in_last) eos_d = 1'b1;
    end

    tail = fifo_head_q ^ fifo_cnt_q[0];
    if (s1_valid_q) begin
      fifo_data_d[tail] = s1_pad_q ? '0 : ram_rdata;
      fifo_idx_d[tail]  = s1_idx_q;
    end
    if (pop) fifo_head_d = ~fifo_head_q;
    fifo_cnt_d = fifo_cnt_q + {1'b0, s1_valid_q} - {1'b0, pop};

    unique case (state_q)
      S_WAIT: begin
        if (start_ok)   state_d = S_EMIT;
        else if (eos_q) state_d = S_EOS;
      end
      S_EOS: state_d = start_ok ? S_EMIT : S_DONE;
      S_EMIT: begin
        if (pop && head_last) begin
          base_d      = base_q + HOP_C;
          rd_cnt_d    = base_q + HOP_C;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_WAIT;
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_WAIT;
    endcase

    if (!enable) begin
      state_d     = S_WAIT;
      wr_cnt_d    = '0;
      base_d      = '0;
      rd_cnt_d    = '0;
      eos_d       = 1'b0;
      frame_cnt_d = '0;
      s1_valid_d  = 1'b0;
      fifo_head_d = 1'b0;
      fifo_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WAIT;
      wr_cnt_q    <= '0;
      base_q      <= '0;
      rd_cnt_q    <= '0;
      eos_q       <= 1'b0;
      run_q       <= 1'b0;
      frame_cnt_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_pad_q    <= 1'b0;
      s1_idx_q    <= '0;
      fifo_head_q <= 1'b0;
      fifo_cnt_q  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      base_q      <= base_d;
      rd_cnt_q    <= rd_cnt_d;
      eos_q       <= eos_d;
      run_q       <= run_d;
      frame_cnt_q <= frame_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_pad_q    <= s1_pad_d;
      s1_idx_q    <= s1_idx_d;
      fifo_head_q <= fifo_head_d;
      fifo_cnt_q  <= fifo_cnt_d;
      fifo_data_q <= fifo_data_d;
      fifo_idx_q  <= fifo_idx_d;
    end
  end

endmodule
